// File: rtl/loeffler_dct8_stage1.sv
// loeffler_dct8_stage1
// Microcoded front end of an 8-point Loeffler DCT. The block fetches eight
// signed 8-bit samples from an external synchronous RAM and writes the first
// butterfly stage (four sums, four differences) into a 16-bit scratchpad
// built from one ice40_ebr block RAM. Later DCT stages extend the
// microprogram and read their operands back from the same scratchpad.

// ice40_ebr
// Behavioural model of an iCE40 embedded block RAM: one synchronous write
// port and one registered read port, no reset, contents undefined until
// written.
module ice40_ebr #(
    parameter int addr_width = 8,
    parameter int data_width = 16
) (
    input  logic [data_width-1:0] din,
    input  logic                  write_en,
    input  logic [addr_width-1:0] waddr,
    input  logic                  wclk,
    input  logic [addr_width-1:0] raddr,
    input  logic                  rclk,
    output logic [data_width-1:0] dout
);

    logic [data_width-1:0] mem [0:(2**addr_width)-1];

    // Write port: commit din on the wclk edge when write_en is high.
    always_ff @(posedge wclk) begin
        if (write_en) begin
            mem[waddr] <= din;
        end
    end

    // Read port: dout is a register loaded from mem[raddr] on every rclk edge.
    always_ff @(posedge rclk) begin
        dout <= mem[raddr];
    end

endmodule

module loeffler_dct8_stage1 (
    input  logic       clock,
    input  logic       nreset,
    input  logic [7:0] fetch_data,
    output logic [2:0] fetch_addr,
    output logic       fetch_clk
);

    // Program counter value at which the sequencer parks.
    localparam logic [5:0] PC_HALT = 6'h11;

    // One decoded microinstruction.
    typedef struct packed {
        logic [2:0] faddr;   // external RAM address presented this cycle
        logic       lat_a;   // load operand A from the incoming sample
        logic       lat_b;   // load operand B from the incoming sample
        logic       we;      // scratchpad write at the end of this cycle
        logic [7:0] waddr;   // scratchpad write address
        logic       op_sub;  // 0: A + sample, 1: A - B
    } uop_t;

    // Builds a microinstruction from its fields; keeps the program table
    // readable as one line per pc.
    function automatic uop_t f_uop(
        input logic [2:0] faddr,
        input logic       lat_a,
        input logic       lat_b,
        input logic       we,
        input logic [7:0] waddr,
        input logic       op_sub
    );
        uop_t u;
        u.faddr  = faddr;
        u.lat_a  = lat_a;
        u.lat_b  = lat_b;
        u.we     = we;
        u.waddr  = waddr;
        u.op_sub = op_sub;
        return u;
    endfunction

    // Sign-extends a RAM sample to the 16-bit datapath width.
    function automatic logic signed [15:0] f_sext(input logic [7:0] d);
        return {{8{d[7]}}, d};
    endfunction

    // Butterfly ALU. The sum uses the sample arriving this cycle directly
    // (B is only being loaded on the same edge), while the difference uses
    // the latched B. Results wrap modulo 2^16; there is no saturation.
    function automatic logic signed [15:0] f_alu(
        input logic signed [15:0] a,
        input logic signed [15:0] b_now,
        input logic signed [15:0] b_reg,
        input logic               op_sub
    );
        logic signed [15:0] res;
        if (op_sub) begin
            res = a - b_reg;
        end else begin
            res = a + b_now;
        end
        return res;
    endfunction

    logic        [5:0]  ucode_pc;
    logic signed [15:0] r_a;
    logic signed [15:0] r_b;

    uop_t               w_uop;
    logic signed [15:0] w_sample;
    logic signed [15:0] w_alu;
    logic               w_we;
    logic        [7:0]  w_raddr;
    logic        [15:0] w_scratch_dout;
    logic               w_unused;

    assign fetch_clk = clock;

    // Microcode ROM: for pair i the four steps are fetch x[i], fetch x[7-i]
    // while latching A, latch B and write the sum, write the difference.
    always_comb begin
        w_uop = f_uop(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        case (ucode_pc)
            6'h00: w_uop = f_uop(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
            6'h01: w_uop = f_uop(3'd7, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
            6'h02: w_uop = f_uop(3'd0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0);
            6'h03: w_uop = f_uop(3'd0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b1);
            6'h04: w_uop = f_uop(3'd1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
            6'h05: w_uop = f_uop(3'd6, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
            6'h06: w_uop = f_uop(3'd0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0);
            6'h07: w_uop = f_uop(3'd0, 1'b0, 1'b0, 1'b1, 8'd6, 1'b1);
            6'h08: w_uop = f_uop(3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
            6'h09: w_uop = f_uop(3'd5, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
            6'h0a: w_uop = f_uop(3'd0, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0);
            6'h0b: w_uop = f_uop(3'd0, 1'b0, 1'b0, 1'b1, 8'd5, 1'b1);
            6'h0c: w_uop = f_uop(3'd3, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
            6'h0d: w_uop = f_uop(3'd4, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
            6'h0e: w_uop = f_uop(3'd0, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0);
            6'h0f: w_uop = f_uop(3'd0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b1);
            6'h10: w_uop = f_uop(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);  // NOP
            6'h11: w_uop = f_uop(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);  // HALT
            default: w_uop = f_uop(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        endcase
    end

    assign fetch_addr = w_uop.faddr;
    assign w_sample   = f_sext(fetch_data);
    assign w_alu      = f_alu(r_a, w_sample, r_b, w_uop.op_sub);

    // Gating with nreset guarantees no partial write on an edge that
    // coincides with reset being asserted.
    assign w_we = w_uop.we & nreset;

    // This stage never reads the scratchpad; later stages will drive the
    // read address from their own microcode fields.
    assign w_raddr  = 8'd0;
    assign w_unused = ^w_scratch_dout;

    // Sequencer and operand registers: advance one microinstruction per
    // clock, park at HALT, load A/B from the incoming sample when enabled.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            ucode_pc <= 6'd0;
            r_a      <= 16'sd0;
            r_b      <= 16'sd0;
        end else begin
            if (ucode_pc != PC_HALT) begin
                ucode_pc <= ucode_pc + 6'd1;
            end
            if (w_uop.lat_a) begin
                r_a <= w_sample;
            end
            if (w_uop.lat_b) begin
                r_b <= w_sample;
            end
        end
    end

    ice40_ebr #(
        .addr_width(8),
        .data_width(16)
    ) scratchpad (
        .din      (w_alu),
        .write_en (w_we),
        .waddr    (w_uop.waddr),
        .wclk     (clock),
        .raddr    (w_raddr),
        .rclk     (clock),
        .dout     (w_scratch_dout)
    );

endmodule

// File: tb/tb_loeffler_dct8_stage1.sv
// Bench for loeffler_dct8_stage1: external RAM model, scoreboard of expected
// scratchpad contents and fetch addresses, plus a standalone ice40_ebr check.
module tb_loeffler_dct8_stage1;

    logic       clock;
    logic       nreset;
    logic [7:0] fetch_data;
    logic [2:0] fetch_addr;
    logic       fetch_clk;

    logic [7:0] x [0:7];

    logic [15:0] e_din;
    logic        e_we;
    logic [7:0]  e_waddr;
    logic [7:0]  e_raddr;
    logic [15:0] e_dout;

    logic [15:0] exp_q [$];
    logic [2:0]  addr_q [$];

    int n_checks;
    int n_fail;

    loeffler_dct8_stage1 dut (
        .clock      (clock),
        .nreset     (nreset),
        .fetch_data (fetch_data),
        .fetch_addr (fetch_addr),
        .fetch_clk  (fetch_clk)
    );

    ice40_ebr #(.addr_width(8), .data_width(16)) u_ebr (
        .din      (e_din),
        .write_en (e_we),
        .waddr    (e_waddr),
        .wclk     (clock),
        .raddr    (e_raddr),
        .rclk     (clock),
        .dout     (e_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External synchronous RAM: one cycle read latency on fetch_clk.
    always @(posedge fetch_clk) begin
        fetch_data <= x[fetch_addr];
    end

    function automatic logic [15:0] sx(input logic [7:0] d);
        return {{8{d[7]}}, d};
    endfunction

    // Reference butterfly straight from the mathematical definition.
    task automatic push_expected();
        for (int k = 0; k < 8; k++) begin
            if (k < 4) exp_q.push_back(sx(x[k]) + sx(x[7-k]));
            else       exp_q.push_back(sx(x[7-k]) - sx(x[k]));
        end
    endtask

    task automatic set_x(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7);
        x[0] = a0; x[1] = a1; x[2] = a2; x[3] = a3;
        x[4] = a4; x[5] = a5; x[6] = a6; x[7] = a7;
    endtask

    task automatic hold_reset();
        @(negedge clock);
        nreset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    // Releases reset on a falling edge and counts rising edges to HALT.
    task automatic run_to_halt(input string name);
        int edges;
        edges = 0;
        @(negedge clock);
        nreset = 1'b1;
        #1;
        while (dut.ucode_pc !== 6'h11 && edges < 40) begin
            @(posedge clock);
            #1;
            edges++;
        end
        n_checks++;
        if (edges != 17) begin
            $display("FAIL %s run_length: got %0d edges, required 17", name, edges);
            n_fail++;
        end
    endtask

    task automatic check_mem(input string name);
        logic [15:0] e;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL %s mem[%0d]: scoreboard empty", name, k);
                n_fail++;
            end else begin
                e = exp_q.pop_front();
                if (dut.scratchpad.mem[k] !== e) begin
                    $display("FAIL %s mem[%0d]: got %h, required %h",
                             name, k, dut.scratchpad.mem[k], e);
                    n_fail++;
                end
            end
        end
    endtask

    task automatic test_reset();
        logic c0;
        set_x(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        nreset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        n_checks++;
        if (dut.ucode_pc !== 6'd0) begin
            $display("FAIL reset_pc: got %h, required 00", dut.ucode_pc); n_fail++;
        end
        n_checks++;
        if (fetch_addr !== 3'd0) begin
            $display("FAIL reset_fetch_addr: got %0d, required 0", fetch_addr); n_fail++;
        end
        n_checks++;
        if (dut.r_a !== 16'h0000 || dut.r_b !== 16'h0000) begin
            $display("FAIL reset_ab: got A=%h B=%h, required 0000 0000", dut.r_a, dut.r_b);
            n_fail++;
        end
        c0 = fetch_clk;
        #5;
        n_checks++;
        if (fetch_clk !== ~c0 || fetch_clk !== clock) begin
            $display("FAIL reset_fetch_clk: got %b, required %b", fetch_clk, ~c0);
            n_fail++;
        end
    endtask

    task automatic test_ramp();
        hold_reset();
        set_x(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        push_expected();
        run_to_halt("ramp");
        check_mem("ramp");
    endtask

    // Contents must survive a long reset untouched.
    task automatic test_staleness();
        hold_reset();
        repeat (5) @(negedge clock);
        push_expected();
        check_mem("stale");
        n_checks++;
        if (dut.ucode_pc !== 6'd0) begin
            $display("FAIL stale_pc: got %h, required 00", dut.ucode_pc); n_fail++;
        end
    endtask

    task automatic test_sign_ext();
        hold_reset();
        set_x(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
        push_expected();
        run_to_halt("sext");
        check_mem("sext");
    endtask

    task automatic test_mixed();
        hold_reset();
        set_x(8'h7f, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80);
        push_expected();
        run_to_halt("mixed");
        check_mem("mixed");
    endtask

    // Cycle-by-cycle fetch address and pc, then a long halt with a noisy RAM.
    task automatic test_fetch_seq();
        logic [2:0] ea;
        hold_reset();
        set_x(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8);
        push_expected();
        for (int i = 0; i < 4; i++) begin
            addr_q.push_back(3'(i));
            addr_q.push_back(3'(7 - i));
            addr_q.push_back(3'd0);
            addr_q.push_back(3'd0);
        end
        addr_q.push_back(3'd0);
        addr_q.push_back(3'd0);
        @(negedge clock);
        nreset = 1'b1;
        #1;
        for (int c = 0; c < 18; c++) begin
            ea = addr_q.pop_front();
            n_checks++;
            if (fetch_addr !== ea || dut.ucode_pc !== 6'(c)) begin
                $display("FAIL fseq step %0d: got addr=%0d pc=%h, required addr=%0d pc=%h",
                         c, fetch_addr, dut.ucode_pc, ea, 6'(c));
                n_fail++;
            end
            if (c < 17) begin
                @(posedge clock);
                #1;
            end
        end
        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < 8; k++) x[k] = 8'($urandom);
            @(posedge clock);
            #1;
            n_checks++;
            if (dut.ucode_pc !== 6'h11 || fetch_addr !== 3'd0) begin
                $display("FAIL halt_hold %0d: got pc=%h addr=%0d, required pc=11 addr=0",
                         c, dut.ucode_pc, fetch_addr);
                n_fail++;
            end
        end
        check_mem("halt");
    endtask

    task automatic test_reset_midrun();
        int guard;
        hold_reset();
        set_x(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h99);
        @(negedge clock);
        nreset = 1'b1;
        guard = 0;
        while (dut.ucode_pc !== 6'h06 && guard < 40) begin
            @(posedge clock);
            #1;
            guard++;
        end
        n_checks++;
        if (guard >= 40) begin
            $display("FAIL midrun_reach_pc6: got pc=%h, required 06", dut.ucode_pc);
            n_fail++;
        end
        #2;
        nreset = 1'b0;
        #1;
        n_checks++;
        if (dut.ucode_pc !== 6'd0 || fetch_addr !== 3'd0) begin
            $display("FAIL midrun_async_clear: got pc=%h addr=%0d, required 00 0",
                     dut.ucode_pc, fetch_addr);
            n_fail++;
        end
        set_x(8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1);
        push_expected();
        run_to_halt("midrun");
        check_mem("midrun");
    endtask

    task automatic test_ebr();
        logic [15:0] e;
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h5678);
        exp_q.push_back(16'h1234);
        @(negedge clock);
        e_we = 1'b1; e_waddr = 8'd5; e_din = 16'h1234; e_raddr = 8'd0;
        @(negedge clock);
        e_waddr = 8'd6; e_din = 16'h5678;
        @(negedge clock);
        e_we = 1'b0; e_raddr = 8'd5;
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (e_dout !== e) begin
            $display("FAIL ebr_read5: got %h, required %h", e_dout, e); n_fail++;
        end
        @(negedge clock);
        e_raddr = 8'd6;
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (e_dout !== e) begin
            $display("FAIL ebr_read6: got %h, required %h", e_dout, e); n_fail++;
        end
        @(negedge clock);
        e_we = 1'b0; e_waddr = 8'd5; e_din = 16'hbeef; e_raddr = 8'd5;
        repeat (2) @(posedge clock);
        #1;
        e = exp_q.pop_front();
        n_checks++;
        if (e_dout !== e) begin
            $display("FAIL ebr_no_write: got %h, required %h", e_dout, e); n_fail++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nreset   = 1'b0;
        e_din = 16'h0; e_we = 1'b0; e_waddr = 8'd0; e_raddr = 8'd0;
        for (int k = 0; k < 8; k++) x[k] = 8'd0;
        test_reset();
        test_ramp();
        test_staleness();
        test_sign_ext();
        test_mixed();
        test_fetch_seq();
        test_reset_midrun();
        test_ebr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/loeffler_dct8_stage1.md
# loeffler_dct8_stage1

Microcoded front end of the 8-point Loeffler DCT. It fetches eight signed 8-bit samples from an external synchronous block RAM and computes the first butterfly stage (four sums, four differences) into an internal 16-bit scratchpad. The scratchpad is one `ice40_ebr` instance. Later DCT stages extend the microprogram and read their operands from this scratchpad.

## Interface
- Parameters: none. The block is fixed at 8 points, 8-bit input and a 16-bit scratchpad.
- `clock` in 1: single system clock. Everything is rising-edge.
- `nreset` in 1: asynchronous, active-low reset.
- `fetch_data` in 8: sample from the external RAM, signed int8. It is valid one cycle after its address was presented.
- `fetch_addr` out 3: sample index to read, 0..7.
- `fetch_clk` out 1: read clock for the external RAM. Tied directly to `clock`.
- Observability requirements for the verification bench:
  - 6-bit register `ucode_pc`.
  - Scratchpad instance `scratchpad`, an `ice40_ebr` with array `mem`.
- `ice40_ebr` parameters: `addr_width`, `data_width`.
- `ice40_ebr` ports:
  - `din`, `write_en`, `waddr`, `wclk`: write when `write_en` is high on the `wclk` rising edge.
  - `raddr`, `rclk`, `dout`: `dout` is a register loaded with `mem[raddr]` on each `rclk` rising edge.
  - No reset. Contents are undefined until written.

## Operation
- Scratchpad configuration: `ice40_ebr` with addr_width 8, data_width 16, `wclk` = `clock`.
- Internal state:
  - `ucode_pc` (6 bits).
  - Operand registers A and B (16 bits each).
- A combinational decoder maps `ucode_pc` to a microinstruction with these fields:
  - fetch address,
  - latch-A enable,
  - latch-B enable,
  - write enable,
  - write address,
  - ALU operation (add or sub).
- Sign extension: `fetch_data` is sign-extended to 16 bits before it is used.
- Arithmetic is two's-complement modulo 2^16 and never saturates.
- Program for each pair i = 0..3, with base b = 4i:
  - pc b: `fetch_addr` = i.
  - pc b+1: `fetch_addr` = 7−i. `fetch_data` = x[i]. A ← sext(`fetch_data`) at the end of the cycle.
  - pc b+2: `fetch_addr` = 0. `fetch_data` = x[7−i]. B ← sext(`fetch_data`). Write scratch[i] ← A + sext(`fetch_data`).
  - pc b+3: `fetch_addr` = 0. Write scratch[7−i] ← A − B.
- pc 0x10: NOP, no write.
- pc 0x11: HALT. `ucode_pc` holds at 0x11 until reset. No writes occur and `fetch_addr` = 0.
- Final scratchpad contents:
  - scratch[k] = x[k] + x[7−k] for k < 4.
  - scratch[k] = x[7−k] − x[k] for k ≥ 4.
- Scratchpad entries 8..255 are never written.

## Timing
- Reset values while `nreset` is low:
  - `ucode_pc` = 0, A = 0, B = 0.
  - `fetch_addr` = 0 (decoded from pc 0).
  - No scratchpad writes.
  - `fetch_clk` keeps toggling.
- Execution rate: one microinstruction per clock. `ucode_pc` increments on every rising edge after reset until it reaches 0x11.
- Run length: `ucode_pc` reaches 0x11 on the 17th rising edge after `nreset` deasserts. All eight results are in `mem` at that point.
- External RAM latency: `fetch_addr` presented during cycle n is captured at the end of n. The data is on `fetch_data` throughout cycle n+1.
- Write timing: a scratchpad write is committed on the rising edge that ends its instruction. The sum and difference of one pair are written on consecutive edges.
- Reset asserted mid-run: state clears immediately, with no partial write on that edge. The program restarts from pc 0 on release and rewrites all eight entries.
- Staleness: scratchpad contents persist across reset and are stale until overwritten.
- Halt: changes to `fetch_data` while halted have no effect.

## Test plan
- Ramp input: x = 1..8. Run until pc = 0x11. Required `mem[0..7]` = 0009, 0009, 0009, 0009, ffff, fffd, fffb, fff9.
- Sign extension: all x = 0x80. Required `mem[0..3]` = ff00 and `mem[4..7]` = 0000.
- Mixed signs: x[0] = 0x7f, x[7] = 0x80, all others 0. Required `mem[0]` = ffff, `mem[7]` = 00ff, and all other entries of 0..7 = 0000.
- `fetch_addr` sequence checked cycle by cycle for pc 0..0x11: 0,7,0,0, 1,6,0,0, 2,5,0,0, 3,4,0,0, 0, 0. `ucode_pc` must be 0x11 on exactly the 17th edge after release and must stay there for 20 more cycles.
- Reset mid-run:
  - Assert `nreset` at pc 0x06, which resets pc to 0.
  - Change the RAM to x = 8..1 and release.
  - Required `mem[0..7]` = 0009 ×4, 0001, 0003, 0005, 0007.
- `ice40_ebr` standalone: write 0x1234 to address 5, then read address 5. `dout` = 1234 one `rclk` edge after `raddr` = 5. No write occurs while `write_en` = 0.
